// File: rtl/reflet_vga_rect_fill.sv
// Rectangle fill engine: takes one clipped rectangle command at a time and
// emits one pixel write per unpaused cycle, in raster order, to the VGA bitmap port.
module reflet_vga_rect_fill #(
   parameter int h_size        = 640,
   parameter int v_line        = 480,
   parameter int color_depth   = 8,
   parameter int bit_reduction = 0,
   localparam int HW    = $clog2(h_size) - bit_reduction,
   localparam int VW    = $clog2(v_line) - bit_reduction,
   localparam int H_MAX = h_size >> bit_reduction,
   localparam int V_MAX = v_line >> bit_reduction
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [HW-1:0]          cmd_h_start,
   input  logic [VW-1:0]          cmd_v_start,
   input  logic [HW:0]            cmd_width,
   input  logic [VW:0]            cmd_height,
   input  logic [color_depth-1:0] cmd_R,
   input  logic [color_depth-1:0] cmd_G,
   input  logic [color_depth-1:0] cmd_B,
   input  logic [color_depth-1:0] cmd_a,
   input  logic                   pause,
   output logic                   write_bitmap,
   output logic [HW-1:0]          h_pixel,
   output logic [VW-1:0]          v_pixel,
   output logic [color_depth-1:0] R_out,
   output logic [color_depth-1:0] G_out,
   output logic [color_depth-1:0] B_out,
   output logic [color_depth-1:0] a_out,
   output logic                   busy,
   output logic                   done
);

   typedef enum logic [1:0] {IDLE, CLIP, FILL, DONE} state_t;

   state_t                 state_reg, state_next;
   logic [HW-1:0]          hs_reg;
   logic [VW-1:0]          vs_reg;
   logic [HW:0]            w_reg;
   logic [VW:0]            ht_reg;
   logic [color_depth-1:0] r_reg, g_reg, b_reg, a_reg;
   logic [HW-1:0]          h_reg, h_next;
   logic [VW-1:0]          v_reg, v_next;
   logic                   write_reg, write_next;
   logic                   done_reg, done_next;
   logic                   busy_reg, ready_reg;
   logic                   latch;

   // Sums carry two extra bits so a huge width/height never wraps below the screen edge.
   logic [HW+1:0] h_sum;
   logic [VW+1:0] v_sum;
   logic [HW:0]   h_end;
   logic [VW:0]   v_end;
   logic          empty, row_end, last;

   always_comb begin
      h_sum   = {2'b00, hs_reg} + {1'b0, w_reg};
      v_sum   = {2'b00, vs_reg} + {1'b0, ht_reg};
      h_end   = (h_sum > (HW+2)'(H_MAX)) ? (HW+1)'(H_MAX) : h_sum[HW:0];
      v_end   = (v_sum > (VW+2)'(V_MAX)) ? (VW+1)'(V_MAX) : v_sum[VW:0];
      empty   = (w_reg == '0) || (ht_reg == '0) ||
                ({1'b0, hs_reg} >= (HW+1)'(H_MAX)) ||
                ({1'b0, vs_reg} >= (VW+1)'(V_MAX));
      row_end = (({1'b0, h_reg} + (HW+1)'(1)) == h_end);
      last    = row_end && (({1'b0, v_reg} + (VW+1)'(1)) == v_end);
   end

   // write_reg marks that (h_reg, v_reg) is being written this cycle; the
   // position only advances after a cycle that actually carried a write.
   always_comb begin
      state_next = state_reg;
      h_next     = h_reg;
      v_next     = v_reg;
      write_next = 1'b0;
      done_next  = 1'b0;
      latch      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (cmd_valid) begin
               latch      = 1'b1;
               state_next = CLIP;
            end
         end
         CLIP: begin
            if (empty) begin
               state_next = DONE;
               done_next  = 1'b1;
            end else begin
               state_next = FILL;
               h_next     = hs_reg;
               v_next     = vs_reg;
               write_next = !pause;
            end
         end
         FILL: begin
            if (write_reg && last) begin
               state_next = DONE;
               done_next  = 1'b1;
            end else begin
               if (write_reg) begin
                  if (row_end) begin
                     h_next = hs_reg;
                     v_next = v_reg + VW'(1);
                  end else begin
                     h_next = h_reg + HW'(1);
                  end
               end
               write_next = !pause;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         hs_reg    <= '0;
         vs_reg    <= '0;
         w_reg     <= '0;
         ht_reg    <= '0;
         r_reg     <= '0;
         g_reg     <= '0;
         b_reg     <= '0;
         a_reg     <= '0;
         h_reg     <= '0;
         v_reg     <= '0;
         write_reg <= 1'b0;
         done_reg  <= 1'b0;
         busy_reg  <= 1'b0;
         ready_reg <= 1'b1;
      end else begin
         state_reg <= state_next;
         h_reg     <= h_next;
         v_reg     <= v_next;
         write_reg <= write_next;
         done_reg  <= done_next;
         busy_reg  <= (state_next != IDLE);
         ready_reg <= (state_next == IDLE);
         if (latch) begin
            hs_reg <= cmd_h_start;
            vs_reg <= cmd_v_start;
            w_reg  <= cmd_width;
            ht_reg <= cmd_height;
            r_reg  <= cmd_R;
            g_reg  <= cmd_G;
            b_reg  <= cmd_B;
            a_reg  <= cmd_a;
         end
      end
   end

   assign cmd_ready    = ready_reg;
   assign busy         = busy_reg;
   assign done         = done_reg;
   assign write_bitmap = write_reg;
   assign h_pixel      = h_reg;
   assign v_pixel      = v_reg;
   assign R_out        = r_reg;
   assign G_out        = g_reg;
   assign B_out        = b_reg;
   assign a_out        = a_reg;

endmodule

// File: tb/tb_reflet_vga_rect_fill.sv
// Bench for reflet_vga_rect_fill: table of directed commands, hand-written
// reset / back-to-back sequences, and random commands against a raster model.
module tb_reflet_vga_rect_fill;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid, cmd_ready;
   logic [9:0] cmd_h_start;
   logic [8:0] cmd_v_start;
   logic [10:0] cmd_width;
   logic [9:0] cmd_height;
   logic [7:0] cmd_R, cmd_G, cmd_B, cmd_a;
   logic       pause, write_bitmap, busy, done;
   logic [9:0] h_pixel;
   logic [8:0] v_pixel;
   logic [7:0] R_out, G_out, B_out, a_out;

   int checks = 0;
   int failures = 0;

   typedef struct {
      int hs; int vs; int w; int ht;
      logic [7:0] r; logic [7:0] g; logic [7:0] b; logic [7:0] a;
      int pmode;      // 0 no pause, 1 random pause, 2 two pause cycles after first write
      int exp_w;
      int exp_done;
   } vec_t;

   typedef struct { int h; int v; } pix_t;

   always #5 clk = ~clk;

   reflet_vga_rect_fill dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_h_start(cmd_h_start), .cmd_v_start(cmd_v_start),
      .cmd_width(cmd_width), .cmd_height(cmd_height),
      .cmd_R(cmd_R), .cmd_G(cmd_G), .cmd_B(cmd_B), .cmd_a(cmd_a),
      .pause(pause), .write_bitmap(write_bitmap),
      .h_pixel(h_pixel), .v_pixel(v_pixel),
      .R_out(R_out), .G_out(G_out), .B_out(B_out), .a_out(a_out),
      .busy(busy), .done(done)
   );

   task automatic chk(input string name, input int rel, input longint got, input longint want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s rel=%0d got=0x%0h want=0x%0h", name, rel, got, want);
      end
   endtask

   function automatic longint pix_key(input int h, input int v, input logic [7:0] r,
                                      input logic [7:0] g, input logic [7:0] b, input logic [7:0] a);
      return (longint'(h) << 41) | (longint'(v) << 32) | longint'({r, g, b, a});
   endfunction

   task automatic next_pause(input int mode, inout int pp, output logic p);
      if (mode == 1) p = ($urandom_range(0, 3) == 0);
      else if (pp > 0) begin p = 1'b1; pp--; end
      else p = 1'b0;
   endtask

   task automatic drive_cmd(input vec_t c);
      cmd_h_start = 10'(c.hs);
      cmd_v_start = 9'(c.vs);
      cmd_width   = 11'(c.w);
      cmd_height  = 10'(c.ht);
      cmd_R = c.r; cmd_G = c.g; cmd_B = c.b; cmd_a = c.a;
   endtask

   task automatic wait_ready();
      bit ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (cmd_ready) begin ok = 1; break; end
      end
      chk("ready_wait", 0, longint'(ok), 1);
   endtask

   // Model: the clipped rectangle as a raster-ordered list of pixels; a write
   // appears in a fill cycle exactly when pause was low at the preceding edge.
   task automatic run_cmd(input vec_t c, output int nw, output int done_rel);
      pix_t q[$];
      int   he, ve, rel, pp, bound;
      logic prev;
      he = (c.hs + c.w < 640) ? c.hs + c.w : 640;
      ve = (c.vs + c.ht < 480) ? c.vs + c.ht : 480;
      for (int y = c.vs; y < ve; y++)
         for (int x = c.hs; x < he; x++) q.push_back('{x, y});
      bound = 4 * q.size() + 40;
      nw = 0; done_rel = -1; pp = 0;
      wait_ready();
      drive_cmd(c);
      cmd_valid = 1'b1;
      pause = 1'b0;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      rel = 1;
      chk("clip_state", rel, {busy, cmd_ready, write_bitmap, done}, 4'b1000);
      next_pause(c.pmode, pp, prev);
      pause = prev;
      while (rel < bound) begin
         @(negedge clk);
         rel++;
         if (q.size() > 0) begin
            chk("write_gate", rel, {write_bitmap, done}, {!prev, 1'b0});
            if (write_bitmap) begin
               pix_t e = q.pop_front();
               chk("pixel", rel, pix_key(h_pixel, v_pixel, R_out, G_out, B_out, a_out),
                   pix_key(e.h, e.v, c.r, c.g, c.b, c.a));
               nw++;
               if (c.pmode == 2 && nw == 1) pp = 2;
            end
         end else begin
            chk("done_pulse", rel, {done, busy, write_bitmap}, 3'b110);
            done_rel = rel;
            break;
         end
         next_pause(c.pmode, pp, prev);
         pause = prev;
      end
      pause = 1'b0;
      if (done_rel < 0) begin
         checks++;
         failures++;
         $display("FAIL done_timeout rel=%0d got=no_done want=done", rel);
      end
      @(negedge clk);
      chk("back_to_idle", rel + 1, {cmd_ready, busy, done}, 3'b100);
      $display("cmd (%0d,%0d) %0dx%0d pmode=%0d writes=%0d done_at=%0d",
               c.hs, c.vs, c.w, c.ht, c.pmode, nw, done_rel);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog rel=0 got=timeout want=finish");
      $fatal(1);
   end

   initial begin
      vec_t vt[9];
      vec_t c;
      int   nw, dr, bad, acc2;
      bit   drop, want_w, want_d;

      vt[0] = '{10, 5, 4, 2, 8'hFF, 8'h00, 8'h00, 8'hFF, 0, 8, 10};
      vt[1] = '{636, 478, 8, 4, 8'h00, 8'h80, 8'h00, 8'hFF, 0, 8, 10};
      vt[2] = '{50, 50, 0, 3, 8'h11, 8'h22, 8'h33, 8'h44, 0, 0, 2};
      vt[3] = '{700, 10, 5, 5, 8'h55, 8'h66, 8'h77, 8'h88, 0, 0, 2};
      vt[4] = '{200, 100, 3, 1, 8'h12, 8'h34, 8'h56, 8'h78, 2, 3, 7};
      vt[5] = '{639, 479, 1, 1, 8'hA5, 8'h5A, 8'hC3, 8'h3C, 0, 1, 3};
      vt[6] = '{0, 0, 3, 0, 8'h01, 8'h02, 8'h03, 8'h04, 0, 0, 2};
      vt[7] = '{630, 470, 2000, 1000, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 0, 100, 102};
      vt[8] = '{5, 490, 4, 4, 8'h99, 8'h98, 8'h97, 8'h96, 0, 0, 2};

      reset = 1'b0; cmd_valid = 1'b0; pause = 1'b0;
      cmd_h_start = '0; cmd_v_start = '0; cmd_width = '0; cmd_height = '0;
      cmd_R = '0; cmd_G = '0; cmd_B = '0; cmd_a = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_state", 0, {cmd_ready, busy, done, write_bitmap}, 4'b1000);
      chk("reset_outputs", 0, pix_key(h_pixel, v_pixel, R_out, G_out, B_out, a_out), 0);
      reset = 1'b1;

      for (int i = 0; i < 9; i++) begin
         run_cmd(vt[i], nw, dr);
         chk("tbl_writes", i, nw, vt[i].exp_w);
         chk("tbl_done", i, dr, vt[i].exp_done);
      end

      // Reset in the middle of a 16x16 fill.
      wait_ready();
      c = '{100, 100, 16, 16, 8'h77, 8'h77, 8'h77, 8'h77, 0, 0, 0};
      drive_cmd(c);
      cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (20) @(negedge clk);
      chk("fill_running", 21, {write_bitmap, busy}, 2'b11);
      #2 reset = 1'b0;
      #1;
      chk("reset_async", 0, {write_bitmap, busy, done, cmd_ready}, 4'b0001);
      chk("reset_values", 0, pix_key(h_pixel, v_pixel, R_out, G_out, B_out, a_out), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      bad = 0;
      repeat (6) begin
         @(negedge clk);
         if (done || write_bitmap || !cmd_ready) bad++;
      end
      chk("quiet_after_reset", 0, bad, 0);
      $display("reset mid-fill: quiet_cycles_violations=%0d", bad);
      c = '{5, 7, 3, 2, 8'h21, 8'h43, 8'h65, 8'h87, 0, 0, 0};
      run_cmd(c, nw, dr);
      chk("post_reset_writes", 0, nw, 6);
      chk("post_reset_done", 0, dr, 8);

      // Back-to-back: cmd_valid held across two 2x1 commands.
      wait_ready();
      c = '{20, 30, 2, 1, 8'hAA, 8'hAB, 8'hAC, 8'hAD, 0, 0, 0};
      drive_cmd(c);
      cmd_valid = 1'b1;
      pause = 1'b0;
      acc2 = -1; drop = 0;
      @(posedge clk);
      for (int rel = 1; rel <= 11; rel++) begin
         @(negedge clk);
         if (rel == 1) begin
            c = '{40, 31, 2, 1, 8'h55, 8'h56, 8'h57, 8'h58, 0, 0, 0};
            drive_cmd(c);
         end
         if (drop) cmd_valid = 1'b0;
         want_w = (rel == 2 || rel == 3 || rel == 7 || rel == 8);
         want_d = (rel == 4 || rel == 9);
         chk("b2b_strobe", rel, {write_bitmap, done}, {want_w, want_d});
         if (want_w && write_bitmap) begin
            if (rel < 5)
               chk("b2b_pixel", rel, pix_key(h_pixel, v_pixel, R_out, G_out, B_out, a_out),
                   pix_key(18 + rel, 30, 8'hAA, 8'hAB, 8'hAC, 8'hAD));
            else
               chk("b2b_pixel", rel, pix_key(h_pixel, v_pixel, R_out, G_out, B_out, a_out),
                   pix_key(33 + rel, 31, 8'h55, 8'h56, 8'h57, 8'h58));
         end
         if (cmd_ready && cmd_valid && acc2 < 0) begin
            acc2 = rel;
            drop = 1;
         end
      end
      cmd_valid = 1'b0;
      chk("b2b_accept", 0, acc2, 5);
      $display("back-to-back: second accepted at rel=%0d", acc2);

      // Random commands, biased toward the screen edges, with random pause.
      for (int i = 0; i < 24; i++) begin
         c.hs = ($urandom_range(0, 1) == 1) ? $urandom_range(600, 700) : $urandom_range(0, 620);
         c.vs = ($urandom_range(0, 1) == 1) ? $urandom_range(465, 500) : $urandom_range(0, 470);
         c.w  = $urandom_range(0, 12);
         c.ht = $urandom_range(0, 5);
         c.r = 8'($urandom); c.g = 8'($urandom); c.b = 8'($urandom); c.a = 8'($urandom);
         c.pmode = 1; c.exp_w = 0; c.exp_done = 0;
         run_cmd(c, nw, dr);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reflet_vga_rect_fill.md
# reflet_VGA_rect_fill

Command-driven fill engine that sits directly upstream of the VGA block's bitmap write port. It accepts one rectangle command at a time over a valid/ready handshake and emits one clipped pixel write per cycle. Writes come out in raster order on `write_bitmap`, `h_pixel`, `v_pixel`, `R`/`G`/`B`/`a`. This lets a CPU or bus bridge clear or paint screen regions without generating per-pixel traffic.

## Interface
Parameters:
- `h_size`, 640: visible pixels per line; must match the VGA block.
- `v_line`, 480: visible lines; must match the VGA block.
- `color_depth`, 8: bits per colour channel.
- `bit_reduction`, 0: coordinate down-scaling shared with the VGA block.
- Derived values:
  - HW = $clog2(h_size)-bit_reduction
  - VW = $clog2(v_line)-bit_reduction
  - H_MAX = h_size>>bit_reduction
  - V_MAX = v_line>>bit_reduction

Ports:
- `clk`, in, 1: single clock.
- `reset`, in, 1: asynchronous, active-low.
- `cmd_valid`, in, 1: command present.
- `cmd_ready`, out, 1: engine can accept a command.
- `cmd_h_start`, in, HW: left column.
- `cmd_v_start`, in, VW: top line.
- `cmd_width`, in, HW+1: columns to fill; 0 is legal.
- `cmd_height`, in, VW+1: lines to fill; 0 is legal.
- `cmd_R`, `cmd_G`, `cmd_B`, `cmd_a`, in, color_depth each: fill colour.
- `pause`, in, 1: write bus not granted this cycle; engine holds.
- `write_bitmap`, out, 1: pixel write strobe.
- `h_pixel`, out, HW: write column.
- `v_pixel`, out, VW: write line.
- `R_out`, `G_out`, `B_out`, `a_out`, out, color_depth each: write colour.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse when a command retires.

## Operation
- State IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`&&`cmd_ready`, latch all cmd fields and go to CLIP.
- State CLIP (1 cycle):
  - h_end = min(h_start+width, H_MAX), computed at HW+1 bits with no wrap.
  - v_end = min(v_start+height, V_MAX), computed at VW+1 bits with no wrap.
  - If width==0, height==0, h_start>=H_MAX or v_start>=V_MAX: go to DONE with no writes.
  - Otherwise load h=h_start, v=v_start and go to FILL.
- State FILL:
  - Each cycle with `pause`=0: `write_bitmap`=1 with current h, v and the latched colour.
  - After the write, h++. If h+1==h_end, h returns to h_start and v++.
  - On the write at (h_end-1, v_end-1), go to DONE.
  - With `pause`=1: `write_bitmap`=0 and h, v and state are held.
- State DONE (1 cycle): `done`=1, then go to IDLE.
- `cmd_ready`=0 outside IDLE. Command inputs are ignored while busy.
- Colour outputs drive the latched colour continuously. `h_pixel`/`v_pixel` are meaningful only when `write_bitmap`=1.
- All outputs are registered.
- Reset (async, low), including mid-command:
  - State returns to IDLE.
  - Values: `write_bitmap`=0, `done`=0, `busy`=0, `cmd_ready`=1, coordinates 0, colours 0.
  - The partial rectangle is abandoned and no `done` pulse is produced.

## Timing
- Accept at edge N. CLIP is cycle N+1. The first write is visible in cycle N+2.
- Unpaused, a clipped area Wc×Hc produces writes in cycles N+2 .. N+1+Wc·Hc.
- `done` is high in cycle N+2+Wc·Hc. `cmd_ready` returns high in N+3+Wc·Hc.
- Empty or off-screen command: `done` in N+2, ready in N+3.
- Each paused cycle delays all later events by exactly one cycle.
- Throughput is one pixel per unpaused cycle; there are no idle bubbles between rows.
- Back-to-back: with `cmd_valid` held high, the next command is accepted in the first IDLE cycle.

## Test plan
- Basic fill:
  - Stimulus: h_start=10, v_start=5, w=4, h=2, R=0xFF.
  - Response: 8 writes (10..13,5) then (10..13,6) in cycles N+2..N+9; `done` at N+10; `cmd_ready` at N+11.
- Right/bottom clip:
  - Stimulus: h_start=636, w=8, v_start=478, h=4 (640×480).
  - Response: writes cols 636..639 on lines 478..479 only (8 writes); `done` at N+10.
- Degenerate commands:
  - Stimulus: w=0; also h_start=700.
  - Response: zero writes, `done` at N+2, `busy` high for exactly 2 cycles.
- Pause:
  - Stimulus: 3×1 fill with `pause` high for 2 cycles after the first write.
  - Response: writes (x,y),(x+1,y),(x+2,y) with no duplicates or skips; `done` delayed by 2 cycles.
- Reset mid-fill:
  - Stimulus: assert `reset`=0 asynchronously mid-row during a 16×16 fill.
  - Response: `write_bitmap` drops immediately, no `done` pulse, `cmd_ready`=1 after release; a new command then fills from its own start.
- Back-to-back:
  - Stimulus: two 2×1 commands with `cmd_valid` held.
  - Response: the second is accepted at N+5 and its first write appears at N+7.
